imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Instruction-memory responder at the far end of the processor fetch interface.
- Accepts a program as a byte stream over a valid/ready load port and stores it in an internal array.
- Serves instruction bytes for the processor's 8-bit instruction address.
- Holds the processor in reset while loading, then releases it to run from address 0.

Parameters:
DEPTH, 256, number of instruction bytes stored; power of two, at most 256
NOP_WORD, 8'hC0, byte returned for unloaded addresses and during load (jump +0, no register or memory write)
RELEASE_CYCLES, 2, clock cycles cpu_reset stays high after a load completes; at least 1

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-high
instruction_address  input  8  fetch address (processor pc)
instruction  output  8  fetched instruction byte
load_start  input  1  single-cycle pulse; begins a new program load
load_valid  input  1  load_data is valid this cycle
load_data  input  8  program byte
load_ready  output  1  block accepts load_data this cycle
load_end  input  1  single-cycle pulse; marks the end of the program
cpu_reset  output  1  drives the processor reset input
program_length  output  9  number of bytes in the loaded program (0..DEPTH)
overflow  output  1  sticky; a byte was offered while the array was full

Behaviour:
- States: IDLE, LOAD, RELEASE, RUN.
- Reset (asynchronous) values:
  - state = IDLE, write pointer = 0, program_length = 0, overflow = 0.
  - load_ready = 0, cpu_reset = 1, release counter = 0.
  - Array contents are not cleared.
- IDLE:
  - cpu_reset = 1, load_ready = 0.
  - load_start moves to LOAD next cycle; it clears the write pointer, program_length and overflow.
- LOAD:
  - cpu_reset = 1.
  - load_ready = 1 whenever the write pointer is below DEPTH.
  - A byte is accepted on a rising edge with load_valid && load_ready: stored at the write pointer, pointer +1, program_length +1.
  - load_valid while full (pointer == DEPTH): byte dropped, overflow set to 1, pointer does not wrap.
  - load_end moves to RELEASE and loads the release counter with RELEASE_CYCLES.
  - load_end together with load_valid: the byte is accepted first, then the state transitions.
  - load_start in LOAD restarts the load (pointer and length to 0, overflow cleared). A byte offered in the same cycle is ignored.
- RELEASE:
  - cpu_reset = 1, load_ready = 0.
  - Counter decrements each cycle; at 0 moves to RUN.
  - cpu_reset is therefore high for exactly RELEASE_CYCLES cycles after the load_end edge.
- RUN:
  - cpu_reset = 0, load_ready = 0.
  - load_start drops to LOAD next cycle with cpu_reset = 1 in that same cycle, aborting the running program. It clears pointer, length and overflow as above.
  - load_end and load_valid are ignored.
- instruction (combinational read, zero latency; the processor samples it on the same edge that advances pc):
  - RUN and instruction_address < program_length: array[instruction_address].
  - All other cases: NOP_WORD, including every state other than RUN and addresses at or above program_length.
- Address wrap:
  - instruction_address is 8 bits.
  - With DEPTH < 256, addresses at or above DEPTH return NOP_WORD; they do not alias into the array.
- Empty program (load_end with no bytes): RUN with program_length = 0, so every fetch returns NOP_WORD.
- Reset asserted mid-load or mid-run: immediate return to IDLE with the reset values above. Bytes already written stay in the array but are unreachable until reloaded.

Test Plan:
1. Reset, load_start, stream 8'h14, 8'h29, 8'hC1 with load_valid held, then load_end.
   - Expect program_length = 3.
   - Expect cpu_reset high for 2 cycles after load_end, then low.
   - In RUN, addresses 0, 1, 2 return 14, 29, C1 and address 3 returns C0.
2. Apply gaps in load_valid plus load_end coincident with the last byte (8'h55).
   - Expect the last byte stored and no extra bytes written.
   - Expect length to equal the count of valid cycles.
3. DEPTH = 4: offer 6 bytes.
   - Expect load_ready low after the 4th byte.
   - Expect overflow = 1 and program_length = 4.
   - Expect address 4 to read C0 in RUN.
4. Pulse load_start while in RUN.
   - Expect cpu_reset = 1 and instruction = C0 in the next cycle, and program_length = 0.
   - Reload 2 bytes; old bytes beyond address 1 must read C0.
5. Assert reset asynchronously in the middle of a LOAD burst.
   - Expect cpu_reset = 1, load_ready = 0, state IDLE and length 0 before the next clock edge.
6. load_start with load_valid and 8'hAA in the same cycle during LOAD.
   - Expect 8'hAA not stored and length 0.
   - The next valid byte lands at address 0.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: instruction memory filled over a valid/ready byte stream.
// The processor is held in reset until the load completes, then runs from address 0.
`default_nettype none

module imem_loader #(
  parameter int         DEPTH          = 256,
  parameter logic [7:0] NOP_WORD       = 8'hC0,
  parameter int         RELEASE_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] instruction_address,
  output logic [7:0] instruction,
  input  logic       load_start,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  output logic       load_ready,
  input  logic       load_end,
  output logic       cpu_reset,
  output logic [8:0] program_length,
  output logic       overflow
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES + 1) : 1;
  localparam logic [8:0]       DEPTH_LEN    = 9'(DEPTH);
  localparam logic [CNT_W-1:0] RELEASE_INIT = CNT_W'(RELEASE_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [8:0]       length_next;
  logic             overflow_next;
  logic [CNT_W-1:0] rel_cnt, rel_cnt_next;
  logic             write_en;
  logic [7:0]       mem [DEPTH];

  // program_length doubles as the write pointer; the two always move together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      program_length <= 9'd0;
      overflow       <= 1'b0;
      rel_cnt        <= '0;
    end else begin
      state          <= state_next;
      program_length <= length_next;
      overflow       <= overflow_next;
      rel_cnt        <= rel_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    length_next   = program_length;
    overflow_next = overflow;
    rel_cnt_next  = rel_cnt;
    write_en      = 1'b0;
    load_ready    = 1'b0;
    cpu_reset     = 1'b1;
    case (state)
      IDLE: begin
        if (load_start) begin
          state_next    = LOAD;
          length_next   = 9'd0;
          overflow_next = 1'b0;
        end
      end
      LOAD: begin
        load_ready = (program_length < DEPTH_LEN);
        if (load_start) begin
          length_next   = 9'd0;
          overflow_next = 1'b0;
        end else begin
          if (load_valid) begin
            if (load_ready) begin
              write_en    = 1'b1;
              length_next = program_length + 9'd1;
            end else begin
              overflow_next = 1'b1;
            end
          end
          if (load_end) begin
            state_next   = RELEASE;
            rel_cnt_next = RELEASE_INIT;
          end
        end
      end
      RELEASE: begin
        // Leaving on the edge where the counter reaches zero keeps cpu_reset
        // high for exactly RELEASE_CYCLES cycles after load_end.
        rel_cnt_next = rel_cnt - CNT_W'(1);
        if (rel_cnt <= CNT_W'(1)) begin
          state_next = RUN;
        end
      end
      RUN: begin
        cpu_reset = 1'b0;
        if (load_start) begin
          state_next    = LOAD;
          length_next   = 9'd0;
          overflow_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (write_en) begin
      mem[program_length[ADDR_W-1:0]] <= load_data;
    end
  end

  // program_length never exceeds DEPTH, so this bound also stops aliasing.
  always_comb begin
    instruction = NOP_WORD;
    if ((state == RUN) && ({1'b0, instruction_address} < program_length)) begin
      instruction = mem[instruction_address[ADDR_W-1:0]];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a full-depth and a DEPTH=4 instance share stimulus and
// are each compared every cycle against a byte-array model of the load protocol.
`default_nettype none

module tb_imem_loader;

  localparam int RC = 2;
  localparam int M_IDLE = 0, M_LOAD = 1, M_REL = 2, M_RUN = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] instruction_address = 8'd0;
  logic [7:0] load_data = 8'd0;
  logic       load_start = 1'b0, load_valid = 1'b0, load_end = 1'b0;

  logic [7:0] instr [2];
  logic       ready [2];
  logic       cpu_rst [2];
  logic       ovf [2];
  logic [8:0] plen [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  imem_loader #(.DEPTH(256), .NOP_WORD(8'hC0), .RELEASE_CYCLES(RC)) dut_full (
    .clock(clock), .reset(reset), .instruction_address(instruction_address),
    .instruction(instr[0]), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_ready(ready[0]), .load_end(load_end),
    .cpu_reset(cpu_rst[0]), .program_length(plen[0]), .overflow(ovf[0]));

  imem_loader #(.DEPTH(4), .NOP_WORD(8'hC0), .RELEASE_CYCLES(RC)) dut_small (
    .clock(clock), .reset(reset), .instruction_address(instruction_address),
    .instruction(instr[1]), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_ready(ready[1]), .load_end(load_end),
    .cpu_reset(cpu_rst[1]), .program_length(plen[1]), .overflow(ovf[1]));

  // Reference model: loaded bytes, their count, and the protocol phase.
  int         mmode [2];
  int         mlen  [2];
  int         mrem  [2];
  bit         movf  [2];
  int         cap   [2] = '{256, 4};
  logic [7:0] mmem  [2][256];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mmode[k] = M_IDLE;
      mlen[k]  = 0;
      movf[k]  = 1'b0;
      mrem[k]  = 0;
    end
  endtask

  task automatic model_clock();
    for (int k = 0; k < 2; k++) begin
      case (mmode[k])
        M_IDLE, M_RUN: begin
          if (load_start) begin
            mmode[k] = M_LOAD;
            mlen[k]  = 0;
            movf[k]  = 1'b0;
          end
        end
        M_LOAD: begin
          if (load_start) begin
            mlen[k] = 0;
            movf[k] = 1'b0;
          end else begin
            if (load_valid) begin
              if (mlen[k] < cap[k]) begin
                mmem[k][mlen[k]] = load_data;
                mlen[k]++;
              end else begin
                movf[k] = 1'b1;
              end
            end
            if (load_end) begin
              mmode[k] = M_REL;
              mrem[k]  = RC;
            end
          end
        end
        default: begin
          mrem[k]--;
          if (mrem[k] == 0) mmode[k] = M_RUN;
        end
      endcase
    end
  endtask

  function automatic logic [7:0] exp_instr(input int k, input logic [7:0] a);
    if (mmode[k] == M_RUN && int'(a) < mlen[k]) return mmem[k][a];
    return 8'hC0;
  endfunction

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("cpu_reset[%0d]", k), 32'(cpu_rst[k]), 32'(mmode[k] != M_RUN));
      chk($sformatf("load_ready[%0d]", k), 32'(ready[k]),
          32'(mmode[k] == M_LOAD && mlen[k] < cap[k]));
      chk($sformatf("length[%0d]", k), 32'(plen[k]), 32'(mlen[k]));
      chk($sformatf("overflow[%0d]", k), 32'(ovf[k]), 32'(movf[k]));
    end
    for (int j = 0; j < 2; j++) begin
      if ($urandom_range(0, 1) == 0) instruction_address = 8'($urandom_range(0, 255));
      else instruction_address = 8'($urandom_range(0, 9));
      #1;
      for (int k = 0; k < 2; k++)
        chk($sformatf("instr[%0d]@%0h", k, instruction_address), 32'(instr[k]),
            32'(exp_instr(k, instruction_address)));
    end
  endtask

  task automatic step();
    model_clock();
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic push(input logic [7:0] d);
    load_valid = 1'b1;
    load_data  = d;
    step();
    load_valid = 1'b0;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  task automatic finish_load();
    load_end = 1'b1;
    step();
    load_end = 1'b0;
    repeat (RC) step();
  endtask

  task automatic read_chk(input string tag, input int k, input logic [7:0] a, input logic [7:0] e);
    instruction_address = a;
    #1;
    chk(tag, 32'(instr[k]), 32'(e));
  endtask

  initial begin
    int  n, i;
    bit  ended;

    repeat (3) @(posedge clock);
    #1;
    model_reset();
    chk("reset_cpu_reset", 32'(cpu_rst[0]), 32'd1);
    chk("reset_ready", 32'(ready[0]), 32'd0);
    chk("reset_length", 32'(plen[0]), 32'd0);
    chk("reset_instr", 32'(instr[0]), 32'hC0);
    check_all();
    reset = 1'b0;

    // Basic three-byte program and release timing
    pulse_start();
    push(8'h14); push(8'h29); push(8'hC1);
    load_end = 1'b1;
    step();
    load_end = 1'b0;
    chk("t1_length", 32'(plen[0]), 32'd3);
    chk("t1_rel_a", 32'(cpu_rst[0]), 32'd1);
    step();
    chk("t1_rel_b", 32'(cpu_rst[0]), 32'd1);
    step();
    chk("t1_run", 32'(cpu_rst[0]), 32'd0);
    read_chk("t1_a0", 0, 8'd0, 8'h14);
    read_chk("t1_a1", 0, 8'd1, 8'h29);
    read_chk("t1_a2", 0, 8'd2, 8'hC1);
    read_chk("t1_a3", 0, 8'd3, 8'hC0);

    // Gaps in load_valid, load_end coincident with the last byte
    pulse_start();
    push(8'h11); step(); push(8'h22); step(); step(); push(8'h33);
    load_valid = 1'b1; load_data = 8'h55; load_end = 1'b1;
    step();
    load_valid = 1'b0; load_end = 1'b0;
    chk("t2_length", 32'(plen[0]), 32'd4);
    repeat (RC) step();
    read_chk("t2_last", 0, 8'd3, 8'h55);
    read_chk("t2_past", 0, 8'd4, 8'hC0);

    // Overflow on the DEPTH=4 instance
    pulse_start();
    for (int b = 0; b < 4; b++) push(8'hA0 + 8'(b));
    chk("t3_ready_low", 32'(ready[1]), 32'd0);
    push(8'hA4); push(8'hA5);
    chk("t3_overflow", 32'(ovf[1]), 32'd1);
    chk("t3_length", 32'(plen[1]), 32'd4);
    finish_load();
    read_chk("t3_addr4_small", 1, 8'd4, 8'hC0);
    read_chk("t3_addr4_full", 0, 8'd4, 8'hA4);

    // load_start while running, then a shorter reload
    pulse_start();
    chk("t4_cpu_reset", 32'(cpu_rst[0]), 32'd1);
    chk("t4_length", 32'(plen[0]), 32'd0);
    read_chk("t4_nop", 0, 8'd0, 8'hC0);
    push(8'hB1); push(8'hB2);
    finish_load();
    read_chk("t4_new1", 0, 8'd1, 8'hB2);
    read_chk("t4_stale2", 0, 8'd2, 8'hC0);

    // Asynchronous reset in the middle of a burst
    pulse_start();
    push(8'h01); push(8'h02);
    load_valid = 1'b1; load_data = 8'h03;
    #1 reset = 1'b1;
    #1;
    chk("t5_cpu_reset", 32'(cpu_rst[0]), 32'd1);
    chk("t5_ready", 32'(ready[0]), 32'd0);
    chk("t5_length", 32'(plen[0]), 32'd0);
    model_reset();
    check_all();
    reset = 1'b0;
    step();
    load_valid = 1'b0;
    chk("t5_idle_ignores", 32'(plen[0]), 32'd0);

    // Restart with a coincident byte
    pulse_start();
    push(8'h77);
    load_start = 1'b1; load_valid = 1'b1; load_data = 8'hAA;
    step();
    load_start = 1'b0; load_valid = 1'b0;
    chk("t6_length", 32'(plen[0]), 32'd0);
    push(8'h5A);
    finish_load();
    read_chk("t6_addr0", 0, 8'd0, 8'h5A);
    read_chk("t6_addr1", 0, 8'd1, 8'hC0);

    // Random programs with gaps, restarts and ignored traffic while running
    for (int r = 0; r < 40; r++) begin
      pulse_start();
      n = $urandom_range(0, 7);
      i = 0;
      ended = 1'b0;
      while (i < n) begin
        if ($urandom_range(0, 3) != 0) begin
          load_valid = 1'b1;
          load_data  = 8'($urandom);
          i++;
          if (i == n && $urandom_range(0, 1) == 1) begin
            load_end = 1'b1;
            ended = 1'b1;
          end
        end
        if ($urandom_range(0, 15) == 0) load_start = 1'b1;
        step();
        load_valid = 1'b0; load_end = 1'b0; load_start = 1'b0;
      end
      if (!ended) begin
        load_end = 1'b1;
        step();
        load_end = 1'b0;
      end
      repeat ($urandom_range(RC, RC + 6)) begin
        load_valid = 1'($urandom_range(0, 1));
        load_data  = 8'($urandom);
        load_end   = ($urandom_range(0, 3) == 0);
        step();
      end
      load_valid = 1'b0; load_end = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
